// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the request legality / lane-placement helpers.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

  // A request is legal when funct3 names a supported access for its direction
  // and the address is naturally aligned for the access size.
  function automatic logic lsu_legal(input logic is_store, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by the access; the low funct3 bits carry the size.
  function automatic logic [3:0] lsu_byte_enable(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3[1:0])
      2'd0:    be = 4'b0001 << addr_lo;
      2'd1:    be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated so every possible target lane carries the value.
  function automatic logic [31:0] lsu_write_data(input logic [2:0] funct3, input logic [31:0] data);
    logic [31:0] wd;
    case (funct3[1:0])
      2'd0:    wd = {4{data[7:0]}};
      2'd1:    wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, data-memory and response signals of the load/store unit.
// master = the unit itself, slave = execute stage plus data memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic [4:0]  req_rd;
  logic [31:0] mem_address;
  logic [2:0]  mem_store_operation;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_error;

  modport master (
    input  req_valid, req_is_store, req_funct3, req_address, req_store_data, req_rd,
    output req_ready,
    output mem_address, mem_store_operation, mem_write_data, mem_byte_enable,
    output mem_read_enable, mem_write_enable,
    input  mem_read_data,
    output resp_valid, resp_data, resp_rd, resp_error
  );

  modport slave (
    output req_valid, req_is_store, req_funct3, req_address, req_store_data, req_rd,
    input  req_ready,
    input  mem_address, mem_store_operation, mem_write_data, mem_byte_enable,
    input  mem_read_enable, mem_write_enable,
    output mem_read_data,
    input  resp_valid, resp_data, resp_rd, resp_error
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load alignment: selects the addressed byte/half from a memory
// word and sign- or zero-extends it. Kept separate so a cached load path can reuse it.
module load_store_unit_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend according to funct3.
  always_comb begin
    shifted = word_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'd0, shifted[7:0]};
      F3_HU:   data_o = {16'd0, shifted[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time from execute, issues a single
// read or write strobe to data memory, waits the fixed read latency for loads
// and returns a one-cycle response with the aligned/extended load result.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_READ_LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.master bus
);

  localparam logic [2:0] LAT_CNT = 3'(MEM_READ_LATENCY);

  lsu_state_t  state_q;
  logic        req_ready_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  rd_q;
  logic [2:0]  cnt_q;
  logic [31:0] mem_address_q;
  logic [2:0]  mem_store_op_q;
  logic [31:0] mem_write_data_q;
  logic [3:0]  mem_byte_enable_q;
  logic        mem_read_enable_q;
  logic        mem_write_enable_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic [4:0]  resp_rd_q;
  logic        resp_error_q;
  logic [31:0] load_ext;

  load_store_unit_load_align u_align (
    .word_i    (bus.mem_read_data),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_ext)
  );

  // Request FSM with all bus outputs registered; the memory address/lanes are
  // loaded on accept and left untouched until the next accept, so they stay
  // stable through the whole read wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      req_ready_q        <= 1'b1;
      is_store_q         <= 1'b0;
      funct3_q           <= 3'd0;
      addr_lo_q          <= 2'd0;
      rd_q               <= 5'd0;
      cnt_q              <= 3'd0;
      mem_address_q      <= 32'd0;
      mem_store_op_q     <= 3'd0;
      mem_write_data_q   <= 32'd0;
      mem_byte_enable_q  <= 4'd0;
      mem_read_enable_q  <= 1'b0;
      mem_write_enable_q <= 1'b0;
      resp_valid_q       <= 1'b0;
      resp_data_q        <= 32'd0;
      resp_rd_q          <= 5'd0;
      resp_error_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            is_store_q  <= bus.req_is_store;
            funct3_q    <= bus.req_funct3;
            addr_lo_q   <= bus.req_address[1:0];
            rd_q        <= bus.req_rd;
            if (lsu_legal(bus.req_is_store, bus.req_funct3, bus.req_address[1:0])) begin
              state_q            <= ISSUE;
              mem_address_q      <= {bus.req_address[31:2], 2'b00};
              mem_store_op_q     <= bus.req_funct3;
              mem_byte_enable_q  <= lsu_byte_enable(bus.req_funct3, bus.req_address[1:0]);
              mem_write_data_q   <= lsu_write_data(bus.req_funct3, bus.req_store_data);
              mem_read_enable_q  <= ~bus.req_is_store;
              mem_write_enable_q <= bus.req_is_store;
            end else begin
              // Illegal requests never touch memory; answer with an error at once.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= 32'd0;
              resp_rd_q    <= bus.req_rd;
              resp_error_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          mem_read_enable_q  <= 1'b0;
          mem_write_enable_q <= 1'b0;
          cnt_q              <= 3'd1;
          if (is_store_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= rd_q;
            resp_error_q <= 1'b0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // The wait state lasts MEM_READ_LATENCY cycles; the last one is when
          // the read word is on mem_read_data.
          if (cnt_q == LAT_CNT) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= load_ext;
            resp_rd_q    <= rd_q;
            resp_error_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready           = req_ready_q;
  assign bus.mem_address         = mem_address_q;
  assign bus.mem_store_operation = mem_store_op_q;
  assign bus.mem_write_data      = mem_write_data_q;
  assign bus.mem_byte_enable     = mem_byte_enable_q;
  assign bus.mem_read_enable     = mem_read_enable_q;
  assign bus.mem_write_enable    = mem_write_enable_q;
  assign bus.resp_valid          = resp_valid_q;
  assign bus.resp_data           = resp_data_q;
  assign bus.resp_rd             = resp_rd_q;
  assign bus.resp_error          = resp_error_q;

endmodule
